// File: rtl/gf_pkg.sv
// Shared constants and types for the GF(2^M) multiplier operand feeder.
// Build option: GF_FEED_BYPASS_EN (see gf_mult_feeder).
package gf_pkg;

   localparam int unsigned GF_M = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } gf_state_t;

   typedef struct packed {
      logic [1:GF_M] a;
      logic [1:GF_M] b;
   } gf_pair_t;

   localparam int unsigned GF_PAIR_W = $bits(gf_pair_t);

endpackage

// File: rtl/gf_pair_fifo.sv
// Small operand-pair FIFO (power-of-two depth) with registered full/empty
// and a combinational look-ahead of next-cycle fullness.
module gf_pair_fifo
   import gf_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  gf_pair_t wr_data,
   output gf_pair_t rd_data_c,
   output logic     empty,
   output logic     full,
   output logic     full_nxt_c
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   gf_pair_t               mem_q [DEPTH];
   gf_pair_t               mem_d [DEPTH];
   logic     [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic     [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic     [CNT_W-1:0]   count_q, count_d;
   logic                   empty_q, empty_d;
   logic                   full_q, full_d;
   logic                   do_push, do_pop;

   // Next-state: pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_push  = push && !full_q;
      do_pop   = pop && !empty_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      empty_d = (count_d == CNT_W'(0));
      full_d  = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign rd_data_c  = mem_q[rd_ptr_q];
   assign empty      = empty_q;
   assign full       = full_q;
   assign full_nxt_c = full_d;

endmodule

// File: rtl/gf_mult_feeder.sv
// Operand feeder for the GF(2^M) systolic multiplier: holds A in parallel and
// serialises B MSB-first with first/last framing. Option: GF_FEED_BYPASS_EN.
module gf_mult_feeder
   import gf_pkg::*;
#(
   parameter int unsigned M     = GF_M,
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:M] a_in,
   input  logic [1:M] b_in,
   output logic       v_out,
   output logic [1:M] a_out,
   output logic       b_bit,
   output logic       first,
   output logic       last,
   output logic [1:8] op_count
);

   localparam int unsigned CNT_W = $clog2(M + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M);

   gf_state_t          state_q, state_d;
   logic [1:M]         a_reg_q, a_reg_d;
   logic [1:M]         b_sh_q, b_sh_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               in_ready_q, in_ready_d;
   logic               v_out_q, v_out_d;
   logic [1:M]         a_out_q, a_out_d;
   logic               b_bit_q, b_bit_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic [1:8]         op_count_q, op_count_d;

   gf_pair_t           wr_pair;
   gf_pair_t           fifo_rd_c;
   gf_pair_t           ld_pair_c;
   logic               fifo_empty, fifo_full, fifo_full_nxt_c;
   logic               fifo_push_c, fifo_pop_c;
   logic               bypass_c, load_c;

   assign wr_pair = '{a: a_in, b: b_in};

   gf_pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .push       (fifo_push_c),
      .pop        (fifo_pop_c),
      .wr_data    (wr_pair),
      .rd_data_c  (fifo_rd_c),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .full_nxt_c (fifo_full_nxt_c)
   );

   // Sequencing: load from FIFO (or bypass), then shift B out over M cycles.
   always_comb begin
`ifdef GF_FEED_BYPASS_EN
      bypass_c = (state_q == IDLE) && fifo_empty && in_valid && in_ready_q;
`else
      bypass_c = 1'b0;
`endif
      fifo_push_c = in_valid && in_ready_q && !fifo_full && !bypass_c;
      fifo_pop_c  = 1'b0;
      load_c      = 1'b0;
      ld_pair_c   = fifo_rd_c;
      state_d     = state_q;
      a_reg_d     = a_reg_q;
      b_sh_d      = b_sh_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load_c     = 1'b1;
               fifo_pop_c = 1'b1;
            end else if (bypass_c) begin
               load_c    = 1'b1;
               ld_pair_c = wr_pair;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               if (!fifo_empty) begin
                  load_c     = 1'b1;
                  fifo_pop_c = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               b_sh_d = {b_sh_q[2:M], 1'b0};
               cnt_d  = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_c) begin
         state_d = SHIFT;
         a_reg_d = ld_pair_c.a;
         b_sh_d  = ld_pair_c.b;
         cnt_d   = CNT_ONE;
      end
   end

   // Output stage: one register behind the shifter so every port is a flop.
   always_comb begin
      v_out_d    = (state_q == SHIFT);
      a_out_d    = v_out_d ? a_reg_q : '0;
      b_bit_d    = v_out_d && b_sh_q[1];
      first_d    = v_out_d && (cnt_q == CNT_ONE);
      last_d     = v_out_d && (cnt_q == CNT_LAST);
      op_count_d = op_count_q + 8'(last_q);
      in_ready_d = !fifo_full_nxt_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         a_reg_q    <= '0;
         b_sh_q     <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         v_out_q    <= 1'b0;
         a_out_q    <= '0;
         b_bit_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         a_reg_q    <= a_reg_d;
         b_sh_q     <= b_sh_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         v_out_q    <= v_out_d;
         a_out_q    <= a_out_d;
         b_bit_q    <= b_bit_d;
         first_q    <= first_d;
         last_q     <= last_d;
         op_count_q <= op_count_d;
      end
   end

   assign in_ready = in_ready_q;
   assign v_out    = v_out_q;
   assign a_out    = a_out_q;
   assign b_bit    = b_bit_q;
   assign first    = first_q;
   assign last     = last_q;
   assign op_count = op_count_q;

endmodule
